// File: rtl/ps_spike_arbiter.sv
// ---------------------------------------------------------------------------
// ps_spike_arbiter
//
// Merges the output-spike packet streams of N_ADDERS partial-sum adders onto
// the single link towards spike memory.
//   * Spike packets are forwarded in round-robin order through a one-deep
//     output register (full throughput: drain and refill in the same cycle).
//   * Each adder's per-timestep done packet is absorbed. Once every adder has
//     reported done, a single merged done packet is emitted.
//   * The timestep index advances when memory accepts the merged done packet.
//     run_done is set when the last timestep of the run closes.
//
// Packet layout (WIDTH = 64):
//   [63:60] src, [59:56] dst, [55:54] type, [53:10] zero, [9:0] spike addr.
//   Done packet: type == 2'b11 and addr == 10'h3FF. Anything else is a spike.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   in_valid/in_ready per-adder handshake (in_ready is one-hot or zero)
//   in_data           adder i at bits [i*WIDTH +: WIDTH]
//   out_valid/out_ready/out_data  registered stream towards memory
//   timestep          current timestep index
//   ts_done           one-cycle pulse after the merged done packet is accepted
//   run_done          sticky end-of-run flag, cleared only by rst
//
// Optional build macro SPIKE_COUNT_EN adds:
//   spike_count       spike packets accepted by memory this timestep (saturating)
//   last_spike_count  spike_count captured when the timestep closes
// ---------------------------------------------------------------------------
module ps_spike_arbiter #(
    parameter int unsigned N_ADDERS      = 5,
    parameter int unsigned WIDTH         = 64,
    parameter int unsigned NUM_TIMESTEPS = 10,
    parameter logic [3:0]  ARB_ADDR      = 4'b1011,
    parameter logic [3:0]  MEM_ADDR      = 4'b0000,
    localparam int unsigned TsW = (NUM_TIMESTEPS > 1) ? $clog2(NUM_TIMESTEPS) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_ADDERS-1:0]       in_valid,
    input  logic [N_ADDERS*WIDTH-1:0] in_data,
    output logic [N_ADDERS-1:0]       in_ready,
    output logic                      out_valid,
    output logic [WIDTH-1:0]          out_data,
    input  logic                      out_ready,
    output logic [TsW-1:0]            timestep,
    output logic                      ts_done,
    output logic                      run_done
`ifdef SPIKE_COUNT_EN
    ,
    output logic [15:0]               spike_count,
    output logic [15:0]               last_spike_count
`endif
);

    localparam int unsigned PtrW = $clog2(N_ADDERS);
    localparam logic [PtrW:0]   NumAdders = (PtrW + 1)'(N_ADDERS);
    localparam logic [PtrW-1:0] LastPtr   = PtrW'(N_ADDERS - 1);
    localparam logic [TsW-1:0]  LastTs    = TsW'(NUM_TIMESTEPS - 1);
    localparam logic [WIDTH-1:0] DonePkt  =
        {ARB_ADDR, MEM_ADDR, 2'b11, {(WIDTH - 20){1'b0}}, 10'h3FF};

    typedef enum logic [0:0] {
        StCollect,
        StEmit
    } stateT;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    stateT               stateQ, stateD;
    logic                outValidQ, outValidD;
    logic [WIDTH-1:0]    outDataQ, outDataD;
    logic [PtrW-1:0]     rrPtrQ, rrPtrD;
    logic [N_ADDERS-1:0] doneFlagsQ, doneFlagsD;
    logic [TsW-1:0]      timestepQ, timestepD;
    logic                tsDoneQ, tsDoneD;
    logic                runDoneQ, runDoneD;

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    logic                slotFree;
    logic                outAccept;
    logic                allDone;
    logic [N_ADDERS-1:0] eligible;
    logic                grantValid;
    logic [PtrW-1:0]     grantIdx;
    logic [WIDTH-1:0]    grantData;
    logic                grantIsDone;

    assign slotFree  = !outValidQ || out_ready;
    assign outAccept = outValidQ && out_ready;
    assign allDone   = &doneFlagsQ;
    assign eligible  = in_valid & ~doneFlagsQ;

    // Cyclic search for the first eligible adder at or after rrPtrQ. Grants
    // only when the output register can take a packet this cycle.
    always_comb begin
        logic [PtrW:0] cand;
        cand       = '0;
        grantValid = 1'b0;
        grantIdx   = '0;
        if (!rst && (stateQ == StCollect) && slotFree && !allDone) begin
            for (int k = 0; k < N_ADDERS; k++) begin
                cand = {1'b0, rrPtrQ} + k[PtrW:0];
                if (cand >= NumAdders) begin
                    cand = cand - NumAdders;
                end
                if (!grantValid && eligible[cand[PtrW-1:0]]) begin
                    grantValid = 1'b1;
                    grantIdx   = cand[PtrW-1:0];
                end
            end
        end
    end

    always_comb begin
        grantData = '0;
        for (int i = 0; i < N_ADDERS; i++) begin
            if (grantIdx == i[PtrW-1:0]) begin
                grantData = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    assign grantIsDone = (grantData[WIDTH-9 -: 2] == 2'b11) && (grantData[9:0] == 10'h3FF);

    always_comb begin
        in_ready = '0;
        if (grantValid) begin
            in_ready[grantIdx] = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Next state
    // ------------------------------------------------------------------
    always_comb begin
        stateD     = stateQ;
        outValidD  = outValidQ;
        outDataD   = outDataQ;
        rrPtrD     = rrPtrQ;
        doneFlagsD = doneFlagsQ;
        timestepD  = timestepQ;
        tsDoneD    = 1'b0;
        runDoneD   = runDoneQ;

        case (stateQ)
            StCollect: begin
                // Whatever sits in the output register drains this cycle.
                if (slotFree) begin
                    outValidD = 1'b0;
                end
                if (allDone) begin
                    // A held spike must leave before the merged done packet.
                    if (slotFree) begin
                        outValidD = 1'b1;
                        outDataD  = DonePkt;
                        stateD    = StEmit;
                    end
                end else if (grantValid) begin
                    rrPtrD = (grantIdx == LastPtr) ? '0 : grantIdx + 1'b1;
                    if (grantIsDone) begin
                        doneFlagsD[grantIdx] = 1'b1;
                    end else begin
                        outValidD = 1'b1;
                        outDataD  = grantData;
                    end
                end
            end
            StEmit: begin
                if (outAccept) begin
                    outValidD  = 1'b0;
                    doneFlagsD = '0;
                    tsDoneD    = 1'b1;
                    stateD     = StCollect;
                    if (timestepQ == LastTs) begin
                        timestepD = '0;
                        runDoneD  = 1'b1;
                    end else begin
                        timestepD = timestepQ + 1'b1;
                    end
                end
            end
            default: begin
                stateD = StCollect;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stateQ     <= StCollect;
            outValidQ  <= 1'b0;
            outDataQ   <= '0;
            rrPtrQ     <= '0;
            doneFlagsQ <= '0;
            timestepQ  <= '0;
            tsDoneQ    <= 1'b0;
            runDoneQ   <= 1'b0;
        end else begin
            stateQ     <= stateD;
            outValidQ  <= outValidD;
            outDataQ   <= outDataD;
            rrPtrQ     <= rrPtrD;
            doneFlagsQ <= doneFlagsD;
            timestepQ  <= timestepD;
            tsDoneQ    <= tsDoneD;
            runDoneQ   <= runDoneD;
        end
    end

    assign out_valid = outValidQ;
    assign out_data  = outDataQ;
    assign timestep  = timestepQ;
    assign ts_done   = tsDoneQ;
    assign run_done  = runDoneQ;

`ifdef SPIKE_COUNT_EN
    // ------------------------------------------------------------------
    // Per-timestep spike statistics
    // ------------------------------------------------------------------
    logic [15:0] spikeCountQ, spikeCountD;
    logic [15:0] lastSpikeCountQ, lastSpikeCountD;

    // In StCollect the output register only ever holds spike packets.
    always_comb begin
        spikeCountD     = spikeCountQ;
        lastSpikeCountD = lastSpikeCountQ;
        if (stateQ == StEmit && outAccept) begin
            lastSpikeCountD = spikeCountQ;
            spikeCountD     = '0;
        end else if (stateQ == StCollect && outAccept && spikeCountQ != 16'hFFFF) begin
            spikeCountD = spikeCountQ + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            spikeCountQ     <= '0;
            lastSpikeCountQ <= '0;
        end else begin
            spikeCountQ     <= spikeCountD;
            lastSpikeCountQ <= lastSpikeCountD;
        end
    end

    assign spike_count      = spikeCountQ;
    assign last_spike_count = lastSpikeCountQ;
`endif

endmodule

// File: doc/ps_spike_arbiter.md
Name: ps_spike_arbiter

Overview:
- Clocked arbiter that merges the output-spike packet streams of N_ADDERS partial-sum adders into the single link to spike memory.
- Forwards spike packets in round-robin order.
- Absorbs each adder's per-timestep done packet; emits exactly one merged done packet once every adder has finished the timestep.
- Tracks the timestep index and flags the end of the run.

Parameters:
- N_ADDERS, 5, number of partial-sum adders (requesters), 2..16.
- WIDTH, 64, packet width.
- NUM_TIMESTEPS, 10, timesteps per run; timestep counter wraps after NUM_TIMESTEPS-1.
- ARB_ADDR, 4'b1011, source field [63:60] of the merged done packet.
- MEM_ADDR, 4'b0000, destination field [59:56] of the merged done packet.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  N_ADDERS  per-adder packet valid.
- in_data  in  N_ADDERS*WIDTH  per-adder packet; adder i occupies bits [i*WIDTH +: WIDTH].
- in_ready  out  N_ADDERS  per-adder accept; a transfer occurs when in_valid[i] && in_ready[i].
- out_valid  out  1  packet to memory valid.
- out_data  out  WIDTH  packet to memory.
- out_ready  in  1  memory accept.
- timestep  out  $clog2(NUM_TIMESTEPS)  current timestep index.
- ts_done  out  1  one-cycle pulse when the merged done packet is accepted by memory.
- run_done  out  1  sticky; set when the done packet of timestep NUM_TIMESTEPS-1 is accepted.

Behaviour:
- Packet format: [63:60] src, [59:56] dst, [55:54] type, [53:10] zero, [9:0] spike addr.
- Done packet: type==2'b11 and [9:0]==10'h3FF. Every other packet is a spike packet.
- Reset: out_valid=0, out_data=0, in_ready=0, timestep=0, ts_done=0, run_done=0, rr_ptr=0, done_flags=0, FSM=COLLECT.
- Output stage: single register. slot_free = !out_valid || out_ready.
- out_data must hold stable while out_valid && !out_ready.
- FSM COLLECT:
  - Eligible requester i: in_valid[i] && !done_flags[i].
  - If slot_free, grant the first eligible index at or after rr_ptr (cyclic search).
  - in_ready is one-hot on the granted index, else all zero. in_ready is combinational from state and in_valid.
  - Only one transfer per cycle.
  - Granted spike packet: loaded unchanged into the output register; out_valid=1 the next cycle (1-cycle latency).
  - Granted done packet: sets done_flags[i]; not forwarded; the output register is unchanged.
  - After any grant, rr_ptr = (grant+1) mod N_ADDERS. With no grant, rr_ptr holds.
  - Adders with done_flags set get in_ready=0 until the timestep closes.
  - When done_flags is all ones (evaluated on registered flags) and slot_free: load {ARB_ADDR, MEM_ADDR, 2'b11, 44'b0, 10'h3FF}, go to EMIT.
- FSM EMIT:
  - in_ready all zero.
  - On out_valid && out_ready:
    - pulse ts_done.
    - clear done_flags.
    - if timestep==NUM_TIMESTEPS-1, set timestep=0 and run_done=1; else timestep+1.
    - return to COLLECT.
- Simultaneous events:
  - Draining a spike while accepting a new one in the same cycle is allowed (full throughput).
  - A last done packet arriving while a spike is held waits for slot_free before EMIT.
- run_done clears only on rst.
- rst asserted mid-operation returns every register to its reset value on the next edge. Held packets are discarded.

Optional Feature:
- Macro SPIKE_COUNT_EN.
- Defined:
  - Adds output spike_count (16 bits): the number of spike packets accepted by memory in the current timestep, saturating at 16'hFFFF.
  - Adds output last_spike_count (16 bits): the spike_count value latched on each ts_done.
  - At ts_done, spike_count resets to 0. Both reset to 0.
- Undefined: neither port nor its counters exist. All other behaviour is identical.

Test Plan:
- Adders 0..4 each present one spike packet in the same cycle, out_ready=1 -> forwarded in order 0,1,2,3,4 on consecutive cycles; out_valid first high 1 cycle after the first grant.
- Adder 2 streams 3 spikes, adder 4 streams 3 spikes, rr_ptr=0 -> output order 2,4,2,4,2,4.
- Spike held with out_ready=0 for 5 cycles -> out_data stable, in_ready=0 throughout; when out_ready=1, the next packet follows with no bubble.
- Adders send done in order 4,0,3,1,2, with spikes from 1 and 2 before their done -> spikes forwarded; exactly one packet 64'hB0C00000000003FF; ts_done single pulse; timestep 0->1; adder 4's next packet blocked until then.
- NUM_TIMESTEPS=2, two complete timesteps -> timestep 0->1->0; run_done=1 after the second done packet is accepted.
- rst asserted while in EMIT with out_ready=0 -> next cycle out_valid=0, done_flags=0, timestep=0; with SPIKE_COUNT_EN, spike_count=0.
